// File: rtl/quad_encoder_decoder_if.sv
// Quadrature encoder front-end bus: raw pins and clear request in,
// detent pulse, direction, sticky error and filtered phase out.
interface quad_encoder_decoder_if;
  logic       enc_a;
  logic       enc_b;
  logic       err_clr;
  logic       step;
  logic       upDown;
  logic       err;
  logic [1:0] phase;

  // Side that drives the pins and consumes the decoded outputs
  modport master (
    output enc_a,
    output enc_b,
    output err_clr,
    input  step,
    input  upDown,
    input  err,
    input  phase
  );

  // Decoder side
  modport slave (
    input  enc_a,
    input  enc_b,
    input  err_clr,
    output step,
    output upDown,
    output err,
    output phase
  );
endinterface

// File: rtl/quad_encoder_decoder.sv
// Rotary encoder front end: synchronizes and debounces the A/B pins as a
// pair, decodes Gray-code quarter transitions and folds them into whole
// detents, emitting a one-cycle step pulse with a held direction bit.
module quad_encoder_decoder #(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE         = 4,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  quad_encoder_decoder_if.slave bus
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic        [7:0] DEB_LIMIT = 8'(DEBOUNCE);
  localparam logic signed [3:0] ACC_POS   = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] ACC_NEG   = 4'(-STEPS_PER_DETENT);

  // Position of a pin pair along the forward sequence 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      2'b00:   pos = 2'd0;
      2'b01:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      2'b10:   pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

  logic [SYNC_STAGES-1:0] sync_a_r;
  logic [SYNC_STAGES-1:0] sync_b_r;
  logic [1:0]             s_s;
  logic [1:0]             s_prev_r;
  logic [7:0]             cnt_r;
  logic [7:0]             cnt_next_s;
  logic                   blank_r;
  logic                   accept_s;
  logic [1:0]             move_s;
  logic signed [3:0]      accum_r;
  logic signed [3:0]      accum_inc_s;
  logic signed [3:0]      accum_dec_s;
  state_t                 state_r;
  logic                   step_r;
  logic                   updown_r;
  logic                   err_r;
  logic [1:0]             phase_r;

  assign s_s         = {sync_a_r[SYNC_STAGES-1], sync_b_r[SYNC_STAGES-1]};
  assign move_s      = gray_pos(s_s) - gray_pos(phase_r);
  assign accum_inc_s = accum_r + 4'sd1;
  assign accum_dec_s = accum_r - 4'sd1;

  // Stability counter: counts consecutive cycles the synchronized pair has
  // held a value different from phase. The first cycle at a new value
  // already counts as one, so acceptance lands SYNC_STAGES+DEBOUNCE edges
  // after the pin change. The cycle right after an accept is blanked so
  // accepts are always at least DEBOUNCE+1 cycles apart.
  always_comb begin
    cnt_next_s = 8'd0;
    accept_s   = 1'b0;
    if (blank_r || (s_s == phase_r)) begin
      cnt_next_s = 8'd0;
    end else if (s_s != s_prev_r) begin
      cnt_next_s = 8'd1;
    end else begin
      cnt_next_s = cnt_r + 8'd1;
    end
    if (cnt_next_s == DEB_LIMIT) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Input synchronizer chains and debounce counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_r <= '0;
      sync_b_r <= '0;
      s_prev_r <= 2'b00;
      cnt_r    <= 8'd0;
      blank_r  <= 1'b0;
    end else begin
      sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], bus.enc_a};
      sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], bus.enc_b};
      s_prev_r <= s_s;
      cnt_r    <= accept_s ? 8'd0 : cnt_next_s;
      blank_r  <= accept_s;
    end
  end

  // Decode FSM: first accept only seeds phase, later accepts are decoded
  // into quarter steps, detent pulses and the sticky illegal-move flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_INIT;
      accum_r  <= 4'sd0;
      step_r   <= 1'b0;
      updown_r <= 1'b1;
      err_r    <= 1'b0;
      phase_r  <= 2'b00;
    end else begin
      step_r <= 1'b0;
      if (bus.err_clr) begin
        err_r <= 1'b0;
      end
      if (accept_s) begin
        phase_r <= s_s;
        case (state_r)
          ST_INIT: begin
            state_r <= ST_TRACK;
          end
          ST_TRACK: begin
            case (move_s)
              2'd1: begin
                if (accum_inc_s == ACC_POS) begin
                  step_r   <= 1'b1;
                  updown_r <= 1'b1;
                  accum_r  <= 4'sd0;
                end else begin
                  accum_r  <= accum_inc_s;
                end
              end
              2'd3: begin
                if (accum_dec_s == ACC_NEG) begin
                  step_r   <= 1'b1;
                  updown_r <= 1'b0;
                  accum_r  <= 4'sd0;
                end else begin
                  accum_r  <= accum_dec_s;
                end
              end
              default: begin
                // both bits moved at once; a new error wins over err_clr
                err_r   <= 1'b1;
                accum_r <= 4'sd0;
              end
            endcase
          end
          default: begin
            state_r <= ST_INIT;
          end
        endcase
      end
    end
  end

  assign bus.step   = step_r;
  assign bus.upDown = updown_r;
  assign bus.err    = err_r;
  assign bus.phase  = phase_r;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Bench for quad_encoder_decoder: directed scenarios with literal checks
// followed by randomized pin activity, all compared every cycle against a
// behavioural model built on the history of sampled pin pairs.
module tb_quad_encoder_decoder;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int SPD  = 4;
  localparam int HN   = 32768;

  logic clk = 1'b0;
  logic reset = 1'b1;
  quad_encoder_decoder_if bus ();

  quad_encoder_decoder #(
    .SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .STEPS_PER_DETENT(SPD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int step_cnt = 0;

  // model state
  bit [1:0] hist [HN];
  int  n_e = 100;
  int  last_acc = -100000;
  bit  m_init = 1'b1;
  int  m_acc = 0;
  bit  m_step = 1'b0;
  bit  m_ud = 1'b1;
  bit  m_err = 1'b0;
  bit [1:0] m_phase = 2'b00;
  bit  model_live = 1'b0;

  function automatic int gpos(input bit [1:0] x);
    case (x)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit [1:0] fwd(input bit [1:0] x);
    case (x)
      2'b00: return 2'b01;
      2'b01: return 2'b11;
      2'b11: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit [1:0] rev(input bit [1:0] x);
    case (x)
      2'b01: return 2'b00;
      2'b11: return 2'b01;
      2'b10: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Model: the pair seen by the debounce logic at edge n is the pin sample
  // from edge n-SYNC; it is accepted when the last DEB such samples agree,
  // differ from phase, and the previous accept is at least DEB+1 edges back.
  initial begin
    bit [1:0] v;
    bit stable;
    int d;
    forever begin
      @(posedge clk);
      n_e++;
      if (reset) begin
        for (int k = 0; k < SYNC; k++) hist[(n_e - k) % HN] = 2'b00;
        last_acc = -100000;
        m_init = 1'b1;
        m_acc = 0;
        m_step = 1'b0;
        m_ud = 1'b1;
        m_err = 1'b0;
        m_phase = 2'b00;
      end else begin
        hist[n_e % HN] = {bus.enc_a, bus.enc_b};
        m_step = 1'b0;
        if (bus.err_clr) m_err = 1'b0;
        v = hist[(n_e - SYNC) % HN];
        stable = 1'b1;
        for (int k = 0; k < DEB; k++)
          if (hist[(n_e - SYNC - k) % HN] != v) stable = 1'b0;
        if (v != m_phase && stable && n_e >= last_acc + DEB + 1) begin
          last_acc = n_e;
          if (m_init) begin
            m_init = 1'b0;
          end else begin
            d = (gpos(v) - gpos(m_phase) + 4) % 4;
            if (d == 1) begin
              m_acc++;
              if (m_acc == SPD) begin m_step = 1'b1; m_ud = 1'b1; m_acc = 0; end
            end else if (d == 3) begin
              m_acc--;
              if (m_acc == -SPD) begin m_step = 1'b1; m_ud = 1'b0; m_acc = 0; end
            end else begin
              m_err = 1'b1;
              m_acc = 0;
            end
          end
          m_phase = v;
        end
      end
      model_live = 1'b1;
    end
  end

  // Per-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (bus.step === 1'b1) step_cnt++;
      if (model_live) begin
        total++;
        if ({bus.step, bus.upDown, bus.err, bus.phase} !== {m_step, m_ud, m_err, m_phase}) begin
          bad++;
          $display("FAIL cycle_check t=%0t got step=%b ud=%b err=%b phase=%b want step=%b ud=%b err=%b phase=%b",
                   $time, bus.step, bus.upDown, bus.err, bus.phase, m_step, m_ud, m_err, m_phase);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive(input bit [1:0] ab, input int cycles, input bit clr);
    {bus.enc_a, bus.enc_b} = ab;
    bus.err_clr = clr;
    tick();
    bus.err_clr = 1'b0;
    for (int i = 1; i < cycles; i++) tick();
  endtask

  initial begin
    int c0;
    int lat;
    bit [1:0] cur;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.err_clr = 1'b0;
    reset = 1'b1;
    tick(); tick(); tick();
    check("reset_step", int'(bus.step), 0);
    check("reset_updown", int'(bus.upDown), 1);
    check("reset_phase", int'(bus.phase), 0);
    reset = 1'b0;

    // INIT seeds phase from the first accepted pair
    c0 = step_cnt;
    drive(2'b11, 10, 1'b0);
    check("init_phase", int'(bus.phase), 3);
    check("init_err", int'(bus.err), 0);
    check("init_steps", step_cnt - c0, 0);

    // illegal 11->00 clears the accumulator and raises err
    drive(2'b00, 10, 1'b0);
    check("illegal_err", int'(bus.err), 1);
    drive(2'b00, 3, 1'b1);
    check("errclr_err", int'(bus.err), 0);

    // one forward detent, step 6 edges after the final pin change
    c0 = step_cnt;
    drive(2'b01, 10, 1'b0);
    drive(2'b11, 10, 1'b0);
    drive(2'b10, 10, 1'b0);
    {bus.enc_a, bus.enc_b} = 2'b00;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.step === 1'b1 && lat < 0) lat = k;
    end
    check("fwd_latency", lat, 6);
    check("fwd_steps", step_cnt - c0, 1);
    check("fwd_updown", int'(bus.upDown), 1);

    // one reverse detent
    c0 = step_cnt;
    drive(2'b10, 10, 1'b0);
    drive(2'b11, 10, 1'b0);
    drive(2'b01, 10, 1'b0);
    drive(2'b00, 30, 1'b0);
    check("rev_steps", step_cnt - c0, 1);
    check("rev_updown_held", int'(bus.upDown), 0);

    // two forward, two back: nothing emitted, accumulator back to zero
    c0 = step_cnt;
    drive(2'b01, 10, 1'b0);
    drive(2'b11, 10, 1'b0);
    drive(2'b01, 10, 1'b0);
    drive(2'b00, 10, 1'b0);
    check("walkback_steps", step_cnt - c0, 0);
    drive(2'b01, 10, 1'b0);
    drive(2'b11, 10, 1'b0);
    drive(2'b10, 10, 1'b0);
    check("walkback_three", step_cnt - c0, 0);
    drive(2'b00, 10, 1'b0);
    check("walkback_fourth", step_cnt - c0, 1);

    // 3-cycle glitch is filtered, then an illegal jump
    c0 = step_cnt;
    drive(2'b01, 3, 1'b0);
    drive(2'b00, 10, 1'b0);
    check("glitch_phase", int'(bus.phase), 0);
    drive(2'b11, 10, 1'b0);
    check("jump_err", int'(bus.err), 1);
    check("jump_steps", step_cnt - c0, 0);
    drive(2'b11, 2, 1'b1);
    check("jump_errclr", int'(bus.err), 0);

    // partial detent aborted by reset; the first move afterwards only seeds phase
    c0 = step_cnt;
    drive(2'b10, 10, 1'b0);
    drive(2'b00, 10, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(2'b00, 5, 1'b0);
    drive(2'b01, 10, 1'b0);
    drive(2'b11, 10, 1'b0);
    drive(2'b10, 10, 1'b0);
    drive(2'b00, 10, 1'b0);
    check("rst_abort_three", step_cnt - c0, 0);
    drive(2'b01, 10, 1'b0);
    check("rst_abort_fourth", step_cnt - c0, 1);

    // randomized pin activity, checked every cycle against the model
    cur = 2'b01;
    for (int it = 0; it < 800; it++) begin
      int r;
      int hold;
      bit clr;
      r = $urandom_range(0, 99);
      hold = $urandom_range(1, 12);
      clr = ($urandom_range(0, 19) == 0);
      if (r < 40) begin
        cur = fwd(cur);
        drive(cur, hold, clr);
      end else if (r < 75) begin
        cur = rev(cur);
        drive(cur, hold, clr);
      end else if (r < 82) begin
        cur = cur ^ 2'b11;
        drive(cur, hold, clr);
      end else if (r < 90) begin
        drive(fwd(cur), $urandom_range(1, DEB), clr);
        drive(cur, hold, 1'b0);
      end else if (r < 99) begin
        drive(cur, hold, clr);
      end else begin
        reset = 1'b1;
        drive(cur, $urandom_range(1, 2), 1'b0);
        reset = 1'b0;
      end
    end
    drive(cur, 20, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
